absorb: RTL and testbench

//  Absorb phase of the sponge datapath. It sits directly upstream of squeez.
//  - Accepts a message stream of RWIDTH-bit words and applies 10* padding.
//  - XORs each padded word into the rate register and runs the external G

---
 rtl/absorb_if.sv | 41 ++++
 rtl/absorb.sv | 104 ++++++++++
 tb/tb_absorb.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/absorb_if.sv
// Bundle of the absorb block's message, permutation and output handshakes.
// The slave modport is the absorb block's view; master is the surrounding system.
interface absorb_if #(
    parameter int CWIDTH    = 320,
    parameter int RWIDTH    = 32,
    parameter int LBWIDTH   = 6,
    parameter int CNT_WIDTH = 16
) ();
    logic                 start;
    logic [RWIDTH-1:0]    msg_data;
    logic                 msg_valid;
    logic                 msg_last;
    logic [LBWIDTH-1:0]   msg_last_bits;
    logic                 msg_ready;
    logic                 perm_start;
    logic [RWIDTH-1:0]    perm_r_in;
    logic [CWIDTH-1:0]    perm_c_in;
    logic [RWIDTH-1:0]    perm_r_out;
    logic [CWIDTH-1:0]    perm_c_out;
    logic                 perm_done;
    logic                 out_valid;
    logic                 out_ready;
    logic [RWIDTH-1:0]    r_out;
    logic [CWIDTH-1:0]    c_out;
    logic [CNT_WIDTH-1:0] blocks;
    logic                 busy;

    modport slave (
        input  start, msg_data, msg_valid, msg_last, msg_last_bits,
        input  perm_r_out, perm_c_out, perm_done, out_ready,
        output msg_ready, perm_start, perm_r_in, perm_c_in,
        output out_valid, r_out, c_out, blocks, busy
    );

    modport master (
        output start, msg_data, msg_valid, msg_last, msg_last_bits,
        output perm_r_out, perm_c_out, perm_done, out_ready,
        input  msg_ready, perm_start, perm_r_in, perm_c_in,
        input  out_valid, r_out, c_out, blocks, busy
    );
endinterface

// File: rtl/absorb.sv
// Sponge absorb phase: 10* pads the message, XORs words into the rate and
// drives the external permutation, then offers the final state downstream.
module absorb #(
    parameter int CWIDTH    = 320,
    parameter int RWIDTH    = 32,
    parameter int LBWIDTH   = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    absorb_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, ACCEPT, PERM, PWAIT, PAD, DONE} state_t;

    localparam logic [RWIDTH-1:0] MSB = {1'b1, {(RWIDTH-1){1'b0}}};

    state_t               state, state_nxt;
    logic [RWIDTH-1:0]    r_reg;
    logic [CWIDTH-1:0]    c_reg;
    logic [CNT_WIDTH-1:0] blocks_reg;
    logic                 final_f, pad_f;
    logic [RWIDTH-1:0]    padded;
    int unsigned          lbi;

    // Shifts by >= RWIDTH give zero, so oversized last_bits clamp naturally.
    always_comb begin
        lbi    = 32'(bus.msg_last_bits);
        padded = bus.msg_data & ~({RWIDTH{1'b1}} >> lbi);
        if (bus.msg_last && lbi < RWIDTH)
            padded = padded | (MSB >> lbi);
        else if (!bus.msg_last)
            padded = bus.msg_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ACCEPT;
            ACCEPT:  if (bus.msg_valid) state_nxt = PERM;
            PERM:    state_nxt = PWAIT;
            PWAIT:   if (bus.perm_done)
                         state_nxt = final_f ? DONE : (pad_f ? PAD : ACCEPT);
            PAD:     state_nxt = PERM;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg      <= '0;
            c_reg      <= '0;
            blocks_reg <= '0;
            final_f    <= 1'b0;
            pad_f      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    r_reg      <= '0;
                    c_reg      <= '0;
                    blocks_reg <= '0;
                    final_f    <= 1'b0;
                    pad_f      <= 1'b0;
                end
                ACCEPT: if (bus.msg_valid) begin
                    r_reg <= r_reg ^ padded;
                    if (bus.msg_last) begin
                        if (lbi < RWIDTH) final_f <= 1'b1;
                        else              pad_f   <= 1'b1;
                    end
                end
                PWAIT: if (bus.perm_done) begin
                    r_reg      <= bus.perm_r_out;
                    c_reg      <= bus.perm_c_out;
                    blocks_reg <= blocks_reg + CNT_WIDTH'(1);
                end
                PAD: begin
                    r_reg   <= r_reg ^ MSB;
                    pad_f   <= 1'b0;
                    final_f <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // r_reg/c_reg are frozen in DONE and IDLE, so they double as the held outputs.
    assign bus.msg_ready  = (state == ACCEPT);
    assign bus.perm_start = (state == PERM);
    assign bus.perm_r_in  = r_reg;
    assign bus.perm_c_in  = c_reg;
    assign bus.out_valid  = (state == DONE);
    assign bus.r_out      = r_reg;
    assign bus.c_out      = c_reg;
    assign bus.blocks     = blocks_reg;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_absorb.sv
// Directed bench for absorb with an identity permutation stub (3-cycle latency).
module tb_absorb;
    localparam int CWIDTH    = 320;
    localparam int RWIDTH    = 32;
    localparam int LBWIDTH   = 6;
    localparam int CNT_WIDTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    absorb_if #(.CWIDTH(CWIDTH), .RWIDTH(RWIDTH), .LBWIDTH(LBWIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    absorb #(.CWIDTH(CWIDTH), .RWIDTH(RWIDTH), .LBWIDTH(LBWIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Identity permutation: result appears 3 cycles after perm_start.
    int dly = 0;
    always @(posedge clk) begin
        bus.perm_done <= 1'b0;
        if (bus.perm_start) begin
            bus.perm_r_out <= bus.perm_r_in;
            bus.perm_c_out <= bus.perm_c_in;
            dly            <= 3;
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) bus.perm_done <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [CWIDTH-1:0] obs, input logic [CWIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [RWIDTH-1:0] d, input logic last,
                             input logic [LBWIDTH-1:0] lb, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        while (!bus.msg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.msg_ready) check("ready_timeout", {{(CWIDTH-1){1'b0}}, bus.msg_ready}, 1);
        bus.msg_data      = d;
        bus.msg_last      = last;
        bus.msg_last_bits = lb;
        bus.msg_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {{(CWIDTH-1){1'b0}}, bus.out_valid}, 1);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_valid", {{(CWIDTH-1){1'b0}}, bus.out_valid}, 0);
        check("idle_busy", {{(CWIDTH-1){1'b0}}, bus.busy}, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.msg_data = '0; bus.msg_valid = 1'b0; bus.msg_last = 1'b0;
        bus.msg_last_bits = '0; bus.out_ready = 1'b0;
        bus.perm_r_out = '0; bus.perm_c_out = '0; bus.perm_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {{(CWIDTH-1){1'b0}}, bus.busy}, 0);
        check("rst_ready", {{(CWIDTH-1){1'b0}}, bus.msg_ready}, 0);
        check("rst_valid", {{(CWIDTH-1){1'b0}}, bus.out_valid}, 0);
        check("rst_blocks", CWIDTH'(bus.blocks), 0);
        check("rst_r", CWIDTH'(bus.r_out), 0);

        // 1) single partial word
        pulse_start();
        check("t1_busy", {{(CWIDTH-1){1'b0}}, bus.busy}, 1);
        check("t1_ready", {{(CWIDTH-1){1'b0}}, bus.msg_ready}, 1);
        send_word(32'hAB000000, 1'b1, 6'd8, 0);
        wait_done();
        check("t1_r", CWIDTH'(bus.r_out), CWIDTH'(32'hAB800000));
        check("t1_c", bus.c_out, '0);
        check("t1_blocks", CWIDTH'(bus.blocks), 1);
        release_out();
        check("t1_r_held", CWIDTH'(bus.r_out), CWIDTH'(32'hAB800000));

        // 2) full last word -> extra pad block; 5) hold out_ready low in DONE
        pulse_start();
        send_word(32'hDEADBEEF, 1'b1, 6'd32, 0);
        wait_done();
        check("t2_r", CWIDTH'(bus.r_out), CWIDTH'(32'h5EADBEEF));
        check("t2_blocks", CWIDTH'(bus.blocks), 2);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 1 || i == 3);
            @(negedge clk);
            check("t5_valid", {{(CWIDTH-1){1'b0}}, bus.out_valid}, 1);
            check("t5_r", CWIDTH'(bus.r_out), CWIDTH'(32'h5EADBEEF));
            check("t5_c", bus.c_out, '0);
            check("t5_blocks", CWIDTH'(bus.blocks), 2);
        end
        bus.start = 1'b0;
        release_out();

        // 3) empty message
        pulse_start();
        send_word(32'h0, 1'b1, 6'd0, 0);
        wait_done();
        check("t3_r", CWIDTH'(bus.r_out), CWIDTH'(32'h80000000));
        check("t3_blocks", CWIDTH'(bus.blocks), 1);
        release_out();

        // 4) two words, gapped valid, ready low during the permutation
        pulse_start();
        send_word(32'h12345678, 1'b0, 6'd0, 0);
        check("t4_perm_start", {{(CWIDTH-1){1'b0}}, bus.perm_start}, 1);
        check("t4_perm_r_in", CWIDTH'(bus.perm_r_in), CWIDTH'(32'h12345678));
        check("t4_ready_perm", {{(CWIDTH-1){1'b0}}, bus.msg_ready}, 0);
        @(negedge clk);
        check("t4_ready_pwait", {{(CWIDTH-1){1'b0}}, bus.msg_ready}, 0);
        check("t4_pstart_off", {{(CWIDTH-1){1'b0}}, bus.perm_start}, 0);
        send_word(32'hFF000000, 1'b1, 6'd8, 4);
        wait_done();
        check("t4_r", CWIDTH'(bus.r_out), CWIDTH'(32'hEDB45678));
        check("t4_blocks", CWIDTH'(bus.blocks), 2);
        release_out();

        // 6) reset while waiting for the permutation; late perm_done ignored
        pulse_start();
        send_word(32'hCAFEF00D, 1'b1, 6'd16, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_busy_async", {{(CWIDTH-1){1'b0}}, bus.busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_busy", {{(CWIDTH-1){1'b0}}, bus.busy}, 0);
        check("t6_blocks", CWIDTH'(bus.blocks), 0);
        check("t6_r", CWIDTH'(bus.r_out), 0);
        check("t6_valid", {{(CWIDTH-1){1'b0}}, bus.out_valid}, 0);
        check("t6_ready", {{(CWIDTH-1){1'b0}}, bus.msg_ready}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
